// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU byte memory: bus widths, depth and the byte type.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package cpu_mem_pkg;

  localparam int REG_WIDTH  = 8;
  localparam int ADDR_WIDTH = 16;
  localparam int MEM_DEPTH  = 1024;

  typedef logic [REG_WIDTH-1:0] byte_t;

  // Addresses at or beyond the array size are treated as holes, not aliases.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/cpu_mem_if.sv
// CPU-side memory bus: write enable, write data, address and combinational read data.
// Latency: read data is combinational on the address; writes commit at the clock edge.
// Backpressure: none, the memory always accepts.
// Ports: master drives we/din/addr and samples dout; slave is the memory.
interface cpu_mem_if
  import cpu_mem_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int AW    = ADDR_WIDTH
);

  logic             we;
  logic [WIDTH-1:0] din;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] dout;

  modport master (output we, output din, output addr, input dout);
  modport slave  (input we, input din, input addr, output dout);

endinterface

// File: rtl/cpu_mem.sv
// CPU byte memory: DEPTH x WIDTH registers, combinational read, clocked write, bulk load/monitor.
// Latency: read 0 cycles (combinational); write and bulk load take effect at the clk rising edge.
// Backpressure: none; every access completes, out-of-range writes are silently dropped.
// Ports: clk (inverted phi0), reset_n (async, active low), bus (we/din/addr/dout),
//        override_mem + mem_override_in (bulk load image), mem_monitor (flat live image).
//        The load/monitor ports are for benches only; tie override_mem low in the system.
module cpu_mem
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int WIDTH = REG_WIDTH,
  parameter int AW    = ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cpu_mem_if.slave               bus,
  input  logic                   override_mem,
  input  logic [DEPTH*WIDTH-1:0] mem_override_in,
  output logic [DEPTH*WIDTH-1:0] mem_monitor
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage is deliberately not reset: a bulk load done while reset_n is low
  // has to survive the reset release.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic          addr_ok;
  logic [IW-1:0] idx;
  logic          wr_en;

  assign addr_ok = addr_in_range(32'(bus.addr), DEPTH);
  assign idx     = bus.addr[IW-1:0];
  // Reset only gates the single-byte write path; the bulk load ignores it.
  assign wr_en   = reset_n && bus.we && addr_ok;

  // Bulk load has priority over a coincident single write.
  always_ff @(posedge clk) begin
    if (override_mem) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_override_in[i*WIDTH +: WIDTH];
      end
    end else if (wr_en) begin
      mem_q[idx] <= bus.din;
    end
  end

  // Reset forces the read port low asynchronously without touching the array.
  always_comb begin
    bus.dout = '0;
    if (reset_n && addr_ok) begin
      bus.dout = mem_q[idx];
    end
  end

  // Monitor image tracks the array even during reset.
  for (genvar g = 0; g < DEPTH; g++) begin : g_mon
    assign mem_monitor[g*WIDTH +: WIDTH] = mem_q[g];
  end

endmodule

// File: tb/tb_cpu_mem.sv
module tb_cpu_mem;
  import cpu_mem_pkg::*;

  localparam int DEPTH = MEM_DEPTH;
  localparam int WIDTH = REG_WIDTH;
  localparam int AW    = ADDR_WIDTH;

  logic                   clk;
  logic                   reset_n;
  logic                   override_mem;
  logic [DEPTH*WIDTH-1:0] mem_override_in;
  logic [DEPTH*WIDTH-1:0] mem_monitor;

  cpu_mem_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  cpu_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .override_mem    (override_mem),
    .mem_override_in (mem_override_in),
    .mem_monitor     (mem_monitor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain byte array updated by the documented rules.
  byte_t model [DEPTH];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    byte_t         din;
    byte_t         exp_before;
    byte_t         exp_after;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_monitor(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (bad < 0 && mem_monitor[i*WIDTH +: WIDTH] !== model[i]) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: location %0d got 0x%0h expected 0x%0h at %0t",
               name, bad, mem_monitor[bad*WIDTH +: WIDTH], model[bad], $time);
    end
  endtask

  function automatic byte_t exp_read(input logic [AW-1:0] a);
    if (!reset_n) return 8'h00;
    if (int'(a) >= DEPTH) return 8'h00;
    return model[int'(a)];
  endfunction

  // Wait for the write edge, apply the rules to the model, then step off the edge.
  task automatic edge_step();
    @(posedge clk);
    if (override_mem) begin
      for (int i = 0; i < DEPTH; i++) model[i] = mem_override_in[i*WIDTH +: WIDTH];
    end else if (reset_n && bus.we && int'(bus.addr) < DEPTH) begin
      model[int'(bus.addr)] = bus.din;
    end
    #1;
  endtask

  task automatic load_counting_image();
    for (int i = 0; i < DEPTH; i++) mem_override_in[i*WIDTH +: WIDTH] = 8'(i);
  endtask

  initial begin
    logic [AW-1:0] ra;

    // Power-up in reset with everything idle.
    reset_n         = 1'b0;
    override_mem    = 1'b0;
    mem_override_in = '0;
    bus.we          = 1'b0;
    bus.din         = '0;
    bus.addr        = 16'h0005;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    #2;
    check("reset_dout", bus.dout, 8'h00);

    // Bulk load during reset is retained after release.
    load_counting_image();
    override_mem = 1'b1;
    edge_step();
    override_mem = 1'b0;
    reset_n      = 1'b1;
    bus.addr     = 16'h0005;
    #1;
    check("reset_load_dout", bus.dout, 8'h05);
    check("reset_load_mon5", mem_monitor[47:40], 8'h05);
    check_monitor("reset_load_mon");

    // Write then read; before the edge the old value is visible.
    bus.we   = 1'b1;
    bus.addr = 16'h0010;
    bus.din  = 8'hA5;
    #1;
    check("wr_pre_edge", bus.dout, 8'h10);
    edge_step();
    bus.we = 1'b0;
    #1;
    check("wr_post_edge", bus.dout, 8'hA5);

    // Write attempted in reset is ignored, read forced to zero.
    reset_n  = 1'b0;
    bus.we   = 1'b1;
    bus.addr = 16'h0020;
    bus.din  = 8'h3C;
    #1;
    check("rst_wr_dout", bus.dout, 8'h00);
    edge_step();
    bus.we  = 1'b0;
    reset_n = 1'b1;
    #1;
    check("rst_wr_kept", bus.dout, 8'h20);

    // Bulk load beats a coincident single write.
    for (int i = 0; i < DEPTH; i++) mem_override_in[i*WIDTH +: WIDTH] = 8'h11;
    override_mem = 1'b1;
    bus.we       = 1'b1;
    bus.addr     = 16'h0003;
    bus.din      = 8'hFF;
    edge_step();
    override_mem = 1'b0;
    bus.we       = 1'b0;
    #1;
    check("collision", bus.dout, 8'h11);
    bus.addr = 16'h0010;
    #1;
    check("collision_other", bus.dout, 8'h11);

    // Out-of-range write: reads 0, nothing changes, no wrap to location 0.
    bus.we   = 1'b1;
    bus.addr = 16'h0400;
    bus.din  = 8'h77;
    edge_step();
    bus.we = 1'b0;
    #1;
    check("oor_dout", bus.dout, 8'h00);
    check_monitor("oor_mon");
    check("oor_loc0", mem_monitor[7:0], 8'h11);
    bus.addr = 16'h0000;
    #1;
    check("oor_read0", bus.dout, 8'h11);
    bus.addr = 16'hFFFF;
    #1;
    check("oor_ffff", bus.dout, 8'h00);

    // Asynchronous reset between edges.
    bus.we   = 1'b1;
    bus.addr = 16'h0042;
    bus.din  = 8'hA5;
    edge_step();
    bus.we = 1'b0;
    #1;
    check("async_before", bus.dout, 8'hA5);
    reset_n = 1'b0;
    #1;
    check("async_low", bus.dout, 8'h00);
    reset_n = 1'b1;
    #1;
    check("async_release", bus.dout, 8'hA5);

    // Table-driven single accesses on a fresh counting image.
    load_counting_image();
    override_mem = 1'b1;
    edge_step();
    override_mem = 1'b0;
    vecs[0] = '{1'b1, 16'h0001, 8'h5A, 8'h01, 8'h5A};
    vecs[1] = '{1'b0, 16'h0001, 8'hFF, 8'h5A, 8'h5A};
    vecs[2] = '{1'b1, 16'h03FF, 8'hC3, 8'hFF, 8'hC3};
    vecs[3] = '{1'b1, 16'h0400, 8'h99, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 16'h1234, 8'h42, 8'h00, 8'h00};
    vecs[5] = '{1'b0, 16'h0234, 8'h00, 8'h34, 8'h34};
    vecs[6] = '{1'b1, 16'h0000, 8'hEE, 8'h00, 8'hEE};
    vecs[7] = '{1'b0, 16'h03FF, 8'h00, 8'hC3, 8'hC3};
    vecs[8] = '{1'b1, 16'h0180, 8'h81, 8'h80, 8'h81};
    for (int v = 0; v < 9; v++) begin
      bus.we   = vecs[v].we;
      bus.addr = vecs[v].addr;
      bus.din  = vecs[v].din;
      #1;
      check($sformatf("vec%0d_before", v), bus.dout, vecs[v].exp_before);
      edge_step();
      bus.we = 1'b0;
      #1;
      check($sformatf("vec%0d_after", v), bus.dout, vecs[v].exp_after);
    end
    check_monitor("vec_mon");

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      reset_n      = ($urandom_range(0, 7) != 0);
      override_mem = ($urandom_range(0, 24) == 0);
      bus.we       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) ra = 16'($urandom_range(DEPTH, 65535));
      else                           ra = 16'($urandom_range(0, DEPTH - 1));
      bus.addr = ra;
      bus.din  = 8'($urandom);
      if (override_mem) begin
        for (int i = 0; i < DEPTH; i++) mem_override_in[i*WIDTH +: WIDTH] = 8'($urandom);
      end
      #1;
      check("rand_pre", bus.dout, exp_read(bus.addr));
      edge_step();
      override_mem = 1'b0;
      bus.we       = 1'b0;
      #1;
      check("rand_post", bus.dout, exp_read(bus.addr));
      if (it % 16 == 0) check_monitor("rand_mon");
    end
    check_monitor("final_mon");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_mem.md
CPU_MEM -- requirements
Module: cpu_mem

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk, reset_n.
REQ-002 Parameter DEPTH, default `MEM_DEPTH (1024), number of byte locations.
REQ-003 Parameter WIDTH, default `REG_WIDTH (8), bits per location.
REQ-004 Parameter AW, default `ADDR_WIDTH (16), address bus width.
REQ-005 clk  in  1  write clock; the system connects it to the inverted CPU phi0.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 we  in  1  write enable, active high.
REQ-008 din  in  WIDTH  write data.
REQ-009 addr  in  AW  byte address.
REQ-010 dout  out  WIDTH  read data.
REQ-011 override_mem  in  1  bulk-load strobe, active high.
REQ-012 mem_override_in  in  DEPTH*WIDTH  flat bulk-load image; location i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-013 mem_monitor  out  DEPTH*WIDTH  flat live image of the whole array, same bit ordering as mem_override_in.

Function
REQ-014 Storage SHALL be DEPTH x WIDTH registers.
REQ-015 Read SHALL be combinational: dout = array[addr] in the same cycle, with no clock latency.
REQ-016 An addr >= DEPTH SHALL read 0x00; a write to such an addr SHALL be ignored; addresses SHALL NOT wrap.
REQ-017 Write: on posedge clk, with reset_n=1, we=1, override_mem=0 and addr < DEPTH, array[addr] <= din.
REQ-018 Bulk load: on posedge clk with override_mem=1, every location i SHALL load mem_override_in slice i, regardless of reset_n and we.
REQ-019 When override_mem=1 and we=1 coincide, the bulk load SHALL win and the single write SHALL be dropped.
REQ-020 A write followed by a read of the same addr SHALL return the new data once the edge has occurred; a same-cycle read before the edge SHALL return the old data.
REQ-021 mem_monitor SHALL combinationally reflect the current array contents, updating right after each write or load edge.
REQ-022 The design SHALL have no handshake and no state machine; we is sampled only at posedge clk.

Reset
REQ-023 While reset_n=0, dout SHALL be forced to 0x00 asynchronously.
REQ-024 While reset_n=0, normal writes SHALL be ignored.
REQ-025 Reset SHALL NOT clear the array, so a bulk load during reset SHALL be retained.
REQ-026 Array contents SHALL be undefined after power-up until written or loaded.
REQ-027 While reset_n=0, mem_monitor SHALL show the array contents and SHALL NOT be forced to zero.
REQ-028 If reset_n is asserted mid-operation, any write at a later edge SHALL be suppressed; completed writes SHALL persist.

Structure
REQ-029 REG_WIDTH (8), ADDR_WIDTH (16), MEM_DEPTH and the byte typedef SHALL live in the shared package PKG/pkg.v.
REQ-030 The block SHALL be a single module with no sub-module.
REQ-031 The bulk-load and monitor ports SHALL be used only by test benches and SHALL be tied off (override_mem=0) in the system build.

Verification
REQ-032 Reset load: reset_n=0, image with location i = i[7:0], override_mem=1 for one clk edge, then reset_n=1 -> addr=0x0005 gives dout=0x05 and mem_monitor[47:40]=0x05.
REQ-033 Write/read: reset_n=1, we=1, addr=0x0010, din=0xA5 for one edge -> dout=0xA5 with we=0; a same-cycle read before the edge returns the old value.
REQ-034 Write in reset: reset_n=0, we=1, addr=0x0020, din=0x3C -> after release addr=0x0020 reads its preload value, not 0x3C; dout=0x00 while in reset.
REQ-035 Collision: override_mem=1, we=1, addr=0x0003, din=0xFF, image all 0x11 -> addr=0x0003 reads 0x11.
REQ-036 Out of range: we=1, addr=DEPTH (0x0400), din=0x77 -> dout=0x00, mem_monitor unchanged, location 0x0000 unchanged.
REQ-037 Async reset: drop reset_n between clock edges while dout=0xA5 -> dout=0x00 immediately without a clock edge; raise reset_n -> 0xA5 returns.
